// File: rtl/fft256_reorder_pkg.sv
// fft256_reorder_pkg: shared FFT256 constants, read-FSM states and index bit reversal
package fft256_reorder_pkg;

    localparam int FFT_SIZE = 256;
    localparam int LOG2N    = $clog2(FFT_SIZE);
    localparam int DATA_W   = 16;

    typedef enum logic {IDLE, READ} rd_state_e;

    // Reverse the low n bits of x; bits at and above n come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] x, input int n = LOG2N);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) if (i < n) r = {r[30:0], x[i]};
        return r;
    endfunction

endpackage

// File: rtl/fft256_reorder_ram.sv
// reorder_ram: one ping/pong bank with a write port and a registered read port
module reorder_ram #(
    parameter int W  = 32,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [1<<AW];
    logic [W-1:0] rdata_q;

    // Storage is never reset; the read data appears the cycle after the address.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fft256_reorder.sv
// fft256_reorder: ping/pong buffer turning bit-reversed FFT256 output into natural order
module fft256_reorder #(
    parameter int DATA_W = fft256_reorder_pkg::DATA_W,
    parameter int LOG2N  = fft256_reorder_pkg::LOG2N
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] din_r,
    input  logic signed [DATA_W-1:0] din_i,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] dout_r,
    output logic signed [DATA_W-1:0] dout_i,
    output logic [LOG2N-1:0]         out_idx,
    output logic                     out_last
);

    import fft256_reorder_pkg::*;

    localparam logic [LOG2N-1:0] LAST = '1;

    logic [LOG2N-1:0]         wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, idx1_q, out_idx_q, out_idx_d, waddr;
    logic                     wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, v1_q, bank1_q;
    logic                     out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic                     wr_last, rd_last, issue;
    logic [1:0]               full_q, full_d, set_v, clr_v;
    logic signed [DATA_W-1:0] dout_r_q, dout_r_d, dout_i_q, dout_i_d;
    logic [2*DATA_W-1:0]      rdata [2];
    rd_state_e                state_q, state_d;

    assign waddr = LOG2N'(bitrev(32'(wr_cnt_q), LOG2N));

    for (genvar b = 0; b < 2; b++) begin : g_bank
        reorder_ram #(.W(2*DATA_W), .AW(LOG2N)) u_ram (
            .clk     (clk),
            .we_i    (in_valid && wr_bank_q == 1'(b)),
            .waddr_i (waddr),
            .wdata_i ({din_r, din_i}),
            .raddr_i (rd_cnt_q),
            .rdata_o (rdata[b])
        );
    end

    // Write counter and bank toggle; full flags set by the writer and cleared by the reader (always different banks)
    always_comb begin
        wr_last   = in_valid && wr_cnt_q == LAST;
        wr_cnt_d  = in_valid ? wr_cnt_q + 1'b1 : wr_cnt_q;
        wr_bank_d = wr_bank_q ^ wr_last;
        set_v     = {wr_last && wr_bank_q, wr_last && !wr_bank_q};
        clr_v     = {rd_last && rd_bank_q, rd_last && !rd_bank_q};
        full_d    = (full_q | set_v) & ~clr_v;
    end

    // Read FSM: IDLE also starts on the edge that completes its bank, so address 0 goes out alongside sample 255
    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        rd_bank_d = rd_bank_q;
        issue     = 1'b0;
        rd_last   = 1'b0;
        unique case (state_q)
            IDLE: if (full_q[rd_bank_q] || (wr_last && wr_bank_q == rd_bank_q)) begin
                issue    = 1'b1;
                rd_cnt_d = rd_cnt_q + 1'b1;
                state_d  = READ;
            end
            READ: begin
                issue    = 1'b1;
                rd_cnt_d = rd_cnt_q + 1'b1;
                rd_last  = rd_cnt_q == LAST;
                if (rd_last) begin
                    rd_bank_d = !rd_bank_q;
                    state_d   = full_q[!rd_bank_q] ? READ : IDLE;
                end
            end
        endcase
    end

    // Output stage registers the RAM word one cycle after its address, zeroing everything when not valid
    always_comb begin
        out_valid_d          = v1_q;
        out_idx_d            = v1_q ? idx1_q : '0;
        out_last_d           = v1_q && idx1_q == LAST;
        {dout_r_d, dout_i_d} = v1_q ? rdata[bank1_q] : '0;
    end

    // All control and output state; reset discards any partial or pending frame
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= '0;
            state_q     <= IDLE;
            v1_q        <= 1'b0;
            idx1_q      <= '0;
            bank1_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            dout_r_q    <= '0;
            dout_i_q    <= '0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            state_q     <= state_d;
            v1_q        <= issue;
            idx1_q      <= rd_cnt_q;
            bank1_q     <= rd_bank_q;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            dout_r_q    <= dout_r_d;
            dout_i_q    <= dout_i_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign dout_r    = dout_r_q;
    assign dout_i    = dout_i_q;

endmodule

// File: tb/tb_fft256_reorder.sv
// tb_fft256_reorder: randomized frames checked against a natural-order reference model
module tb_fft256_reorder;

    logic               clk = 1'b0;
    logic               rst = 1'b0, in_valid = 1'b0;
    logic signed [15:0] din_r = '0, din_i = '0;
    logic               out_valid, out_last;
    logic signed [15:0] dout_r, dout_i;
    logic [7:0]         out_idx;

    int vecs = 0, errs = 0, cyc = 0, bad_idle = 0;
    bit mon_en = 1'b0;
    logic [40:0] got_q[$];
    int          cyc_q[$];
    logic signed [15:0] stim_r [512];
    logic signed [15:0] stim_i [512];

    fft256_reorder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .din_r(din_r), .din_i(din_i),
        .out_valid(out_valid), .dout_r(dout_r), .dout_i(dout_i), .out_idx(out_idx), .out_last(out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: record every valid word with its cycle; count any non-zero output while invalid
    always @(negedge clk) if (mon_en) begin
        if (out_valid === 1'b1) begin
            got_q.push_back({out_idx, dout_r, dout_i, out_last});
            cyc_q.push_back(cyc);
        end else if ({out_idx, dout_r, dout_i, out_last} !== '0) bad_idle++;
    end

    function automatic int rev8(int x);
        int r = 0;
        for (int b = 0; b < 8; b++) begin
            r = r * 2 + x % 2;
            x = x / 2;
        end
        return r;
    endfunction

    // Natural index n of frame f holds the sample that arrived at position rev8(n)
    function automatic logic [40:0] exp_word(int f, int n);
        return {8'(n), stim_r[f*256 + rev8(n)], stim_i[f*256 + rev8(n)], 1'(n == 255)};
    endfunction

    task automatic clear_mon();
        got_q.delete();
        cyc_q.delete();
        bad_idle = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; din_r = '0; din_i = '0;
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        clear_mon();
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0; din_r = '0; din_i = '0;
        end
    endtask

    task automatic fill_random(int n);
        for (int k = 0; k < n; k++) begin
            stim_r[k] = 16'($urandom);
            stim_i[k] = 16'($urandom);
        end
    endtask

    // c255 is the cycle stamp at which sample 255 of the first frame is presented
    task automatic drive(int n, bit gaps, output int c255);
        c255 = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            in_valid = 1'b1; din_r = stim_r[k]; din_i = stim_i[k];
            if (k == 255) c255 = cyc;
            if (gaps) begin
                @(negedge clk);
                in_valid = 1'b0; din_r = 16'($urandom); din_i = 16'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vecs++; if (out_last !== 1'b0) begin errs++; $display("FAIL reset_out_last got %b want 0", out_last); end
        vecs++; if (out_idx !== 8'd0) begin errs++; $display("FAIL reset_out_idx got %0d want 0", out_idx); end
        vecs++; if (dout_r !== 16'sd0) begin errs++; $display("FAIL reset_dout_r got %0d want 0", dout_r); end
        vecs++; if (dout_i !== 16'sd0) begin errs++; $display("FAIL reset_dout_i got %0d want 0", dout_i); end
        idle(20);
        vecs++; if (got_q.size() != 0) begin errs++; $display("FAIL reset_quiet got %0d outputs want 0", got_q.size()); end
        vecs++; if (bad_idle != 0) begin errs++; $display("FAIL reset_idle_zero got %0d want 0", bad_idle); end
    endtask

    task automatic test_ramp();
        int c;
        logic [40:0] e;
        clear_mon();
        for (int k = 0; k < 256; k++) begin
            stim_r[k] = 16'(rev8(k));
            stim_i[k] = 16'(-rev8(k));
        end
        drive(256, 1'b0, c);
        idle(300);
        vecs++; if (got_q.size() != 256) begin errs++; $display("FAIL ramp_count got %0d want 256", got_q.size()); end
        for (int j = 0; j < got_q.size() && j < 256; j++) begin
            e = {8'(j), 16'(j), 16'(-j), 1'(j == 255)};
            vecs += 2;
            if (got_q[j] !== e) begin errs++; $display("FAIL ramp_data[%0d] got %h want %h", j, got_q[j], e); end
            if (cyc_q[j] != c + 2 + j) begin errs++; $display("FAIL ramp_cycle[%0d] got %0d want %0d", j, cyc_q[j], c + 2 + j); end
        end
        vecs++; if (bad_idle != 0) begin errs++; $display("FAIL ramp_idle_zero got %0d want 0", bad_idle); end
    endtask

    task automatic test_random(string name, bit gaps, bit refill);
        int c;
        clear_mon();
        if (refill) fill_random(256);
        drive(256, gaps, c);
        idle(300);
        vecs++; if (got_q.size() != 256) begin errs++; $display("FAIL %s_count got %0d want 256", name, got_q.size()); end
        for (int j = 0; j < got_q.size() && j < 256; j++) begin
            vecs += 2;
            if (got_q[j] !== exp_word(0, j)) begin errs++; $display("FAIL %s_data[%0d] got %h want %h", name, j, got_q[j], exp_word(0, j)); end
            if (cyc_q[j] != c + 2 + j) begin errs++; $display("FAIL %s_cycle[%0d] got %0d want %0d", name, j, cyc_q[j], c + 2 + j); end
        end
        vecs++; if (bad_idle != 0) begin errs++; $display("FAIL %s_idle_zero got %0d want 0", name, bad_idle); end
    endtask

    task automatic test_back_to_back();
        int c;
        clear_mon();
        fill_random(512);
        drive(512, 1'b0, c);
        idle(300);
        vecs++; if (got_q.size() != 512) begin errs++; $display("FAIL b2b_count got %0d want 512", got_q.size()); end
        for (int j = 0; j < got_q.size() && j < 512; j++) begin
            vecs += 2;
            if (got_q[j] !== exp_word(j / 256, j % 256)) begin errs++; $display("FAIL b2b_data[%0d] got %h want %h", j, got_q[j], exp_word(j / 256, j % 256)); end
            if (cyc_q[j] != c + 2 + j) begin errs++; $display("FAIL b2b_cycle[%0d] got %0d want %0d", j, cyc_q[j], c + 2 + j); end
        end
    endtask

    task automatic test_extremes();
        int c;
        clear_mon();
        for (int k = 0; k < 256; k++) begin
            stim_r[k] = (k % 4 == 0) ? 16'sh8000 : (k % 4 == 1) ? 16'sh7fff : 16'($urandom);
            stim_i[k] = (k % 2 == 0) ? 16'sh7fff : 16'sh8000;
        end
        drive(256, 1'b0, c);
        idle(300);
        vecs++; if (got_q.size() != 256) begin errs++; $display("FAIL extreme_count got %0d want 256", got_q.size()); end
        for (int j = 0; j < got_q.size() && j < 256; j++) begin
            vecs++;
            if (got_q[j] !== exp_word(0, j)) begin errs++; $display("FAIL extreme_data[%0d] got %h want %h", j, got_q[j], exp_word(0, j)); end
        end
        if (got_q.size() > 128) begin
            vecs++; if (got_q[0][32:1] !== 32'h8000_7fff) begin errs++; $display("FAIL extreme_idx0 got %h want 80007fff", got_q[0][32:1]); end
            vecs++; if (got_q[128][32:1] !== 32'h7fff_8000) begin errs++; $display("FAIL extreme_idx128 got %h want 7fff8000", got_q[128][32:1]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int c;
        fill_random(100);
        drive(100, 1'b0, c);
        do_reset();
        test_random("rst_frame", 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_read();
        int c;
        bit found = 1'b0;
        clear_mon();
        fill_random(256);
        drive(256, 1'b0, c);
        for (int t = 0; t < 300 && !found; t++) begin
            @(negedge clk);
            in_valid = 1'b0;
            found = (out_valid === 1'b1 && out_idx === 8'd50);
        end
        vecs++; if (!found) begin errs++; $display("FAIL rst_read_reach50 got none want out_idx 50 within 300 cycles"); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_read_valid got %b want 0", out_valid); end
        clear_mon();
        idle(300);
        vecs++; if (got_q.size() != 0) begin errs++; $display("FAIL rst_read_quiet got %0d outputs want 0", got_q.size()); end
        vecs++; if (bad_idle != 0) begin errs++; $display("FAIL rst_read_idle_zero got %0d want 0", bad_idle); end
        test_random("rst_read_next", 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_random("random", 1'b0, 1'b1);
        test_random("gaps", 1'b1, 1'b0);
        test_back_to_back();
        test_extremes();
        test_reset_mid_frame();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/fft256_reorder.md
FFT256_REORDER -- requirements
Module: fft256_reorder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the width of each real and imaginary sample (matches the FFT256 output width).
REQ-002 The block SHALL have parameter LOG2N, default 8, meaning log2 of the frame length (256 points).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: din_r/din_i carry a valid FFT output sample this cycle.
REQ-006 The block SHALL have ports din_r and din_i, input, DATA_W bits each, signed: FFT output sample, arriving in bit-reversed index order.
REQ-007 The block SHALL have port out_valid, output, 1 bit: dout_r/dout_i/out_idx are valid this cycle.
REQ-008 The block SHALL have ports dout_r and dout_i, output, DATA_W bits each, signed: sample in natural index order.
REQ-009 The block SHALL have port out_idx, output, LOG2N bits: natural frequency index of the current output sample.
REQ-010 The block SHALL have port out_last, output, 1 bit: high with out_valid when out_idx equals 255.

Function
REQ-011 Storage SHALL be two banks (ping/pong), each 2^LOG2N entries of 2*DATA_W bits, with one synchronous-read RAM per bank.
REQ-012 Write side: wr_cnt (LOG2N bits) SHALL increment only on in_valid; sample k of a frame is written to address bitrev(k) of bank wr_bank.
REQ-013 Gaps: in_valid low SHALL hold wr_cnt and write nothing; a frame may span any number of cycles.
REQ-014 Frame completion: at the edge capturing the sample with wr_cnt=255, the block SHALL set full[wr_bank], toggle wr_bank and wrap wr_cnt to 0.
REQ-015 Read FSM SHALL have states IDLE and READ.
REQ-016 IDLE SHALL go to READ when full[rd_bank] is set; it then issues read address rd_cnt=0.
REQ-017 READ SHALL issue one address per cycle with no backpressure; at rd_cnt=255 it clears full[rd_bank] and toggles rd_bank.
REQ-018 At rd_cnt=255, if the other bank is already full, READ SHALL continue with rd_cnt=0 of that bank on the next cycle with no idle cycle; otherwise it goes to IDLE.
REQ-019 Output registers SHALL be loaded one cycle after the address is issued; out_valid, out_idx and out_last are pipelined to align with RAM data.
REQ-020 Latency: out_valid for out_idx=0 SHALL rise exactly 2 cycles after the cycle in which sample 255 is presented with in_valid, when the read side is IDLE.
REQ-021 Data SHALL pass bit-exact; no rounding, scaling or saturation.
REQ-022 Simultaneous set/clear of full flags on the same edge SHALL be handled; they always target different banks by construction.
REQ-023 With at most one input per cycle, a bank SHALL never be rewritten before it has been fully read; no overflow path exists.
REQ-024 When out_valid is low, dout_r, dout_i, out_idx and out_last SHALL hold 0.

Reset
REQ-025 rst SHALL clear wr_cnt, rd_cnt, wr_bank, rd_bank and both full flags, force the FSM to IDLE, and set out_valid, out_last, out_idx, dout_r and dout_i to 0 at the next edge.
REQ-026 Reset mid-frame or mid-read SHALL discard all partial and pending frames; RAM contents need not be cleared.
REQ-027 The first in_valid sample after rst deasserts SHALL be treated as index 0 of a new frame.

Structure
REQ-028 The shared package SHALL hold the FFT_SIZE (256), LOG2N and DATA_W constants and a bitrev function; FFT256 and this block both use it.
REQ-029 The block SHALL contain one sub-module, reorder_ram: a single-port-write, single-port-read, synchronous-read RAM instantiated twice.

Verification
REQ-030 A bench SHALL drive one frame where din_r = bitrev(k) and din_i = -bitrev(k) for sample k, contiguous; it SHALL check 256 contiguous out_valid cycles with dout_r = out_idx, dout_i = -out_idx, and out_last only at index 255.
REQ-031 A bench SHALL drive two frames back-to-back (512 contiguous in_valid cycles); it SHALL check 512 contiguous out_valid cycles and that frame 2 data is correct with no gap.
REQ-032 A bench SHALL drive one frame with in_valid toggling 1/0 every cycle; it SHALL check identical output data, with out_valid starting 2 cycles after the last sample.
REQ-033 A bench SHALL assert rst after 100 samples, then drive one full frame; it SHALL check exactly 256 outputs, all from the new frame.
REQ-034 A bench SHALL drive samples at the extremes (-32768 and 32767) in both din_r and din_i; it SHALL check that they appear unchanged at the correct natural index.
REQ-035 A bench SHALL assert rst during READ at out_idx=50; it SHALL check that out_valid is 0 from the next edge and that no further outputs appear until a new frame completes.
